// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/pc-select sequencing for load-use, taken branches and multi-cycle execute ops.
module hazard_ctrl #(
  parameter int IDX_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_d_rs1,
  input  logic [IDX_W-1:0] i_d_rs2,
  input  logic             i_d_rs1_used,
  input  logic             i_d_rs2_used,
  input  logic [IDX_W-1:0] i_e_w_idx,
  input  logic             i_e_wb_en,
  input  logic             i_e_is_load,
  input  logic             i_e_br_taken,
  input  logic             i_e_mc_req,
  input  logic             i_mc_done,
  output logic             o_mc_start,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_pc_sel,
  output logic             o_mc_busy,
  output logic             o_mc_err,
  output logic [CNT_W-1:0] o_stall_cnt
);
  localparam logic RUN     = 1'b0;
  localparam logic MC_WAIT = 1'b1;
  localparam int   TW      = $clog2(TIMEOUT);
  logic             state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_use, in_run, in_wait, start, br, lu, wait_stall, tmo;
  assign load_use = i_e_is_load & i_e_wb_en & (i_e_w_idx != '0) &
                    ((i_d_rs1_used & (i_d_rs1 == i_e_w_idx)) | (i_d_rs2_used & (i_d_rs2 == i_e_w_idx)));
  // Gating with rst forces every control low while reset is held.
  assign in_run     = rst & (state_q == RUN);
  assign in_wait    = rst & (state_q == MC_WAIT);
  assign start      = in_run & i_e_mc_req;
  assign br         = in_run & ~i_e_mc_req & i_e_br_taken;
  assign lu         = in_run & ~i_e_mc_req & ~i_e_br_taken & load_use;
  assign wait_stall = in_wait & ~i_mc_done;
  assign tmo        = wait_stall & (timer_q == TW'(TIMEOUT - 1));
  assign o_mc_start  = start;
  assign o_stall_f   = start | lu | wait_stall;
  assign o_stall_d   = start | lu | wait_stall;
  assign o_stall_e   = start | wait_stall;
  assign o_flush_d   = br;
  assign o_flush_e   = br | lu;
  assign o_pc_sel    = br;
  assign o_mc_busy   = in_wait;
  assign o_mc_err    = err_q;
  assign o_stall_cnt = cnt_q;
  always_comb begin
    state_d = start ? MC_WAIT : (in_wait & (i_mc_done | tmo)) ? RUN : state_q;
    timer_d = start ? '0 : wait_stall ? timer_q + TW'(1) : timer_q;
    err_d   = err_q | tmo;
    cnt_d   = (o_stall_f & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int IDX_W = 5, TIMEOUT = 8, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1;
  logic [IDX_W-1:0] rs1 = '0, rs2 = '0, widx = '0;
  logic rs1u = 0, rs2u = 0, wb = 0, ld = 0, br = 0, mc = 0, done = 0;
  logic mc_start, stall_f, stall_d, stall_e, flush_d, flush_e, pc_sel, busy, err;
  logic [CNT_W-1:0] cnt;
  int n_tests = 0, n_fail = 0;
  bit m_busy = 0, m_err = 0;
  int m_waited = 0, m_cnt = 0;

  hazard_ctrl #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_d_rs1(rs1), .i_d_rs2(rs2), .i_d_rs1_used(rs1u), .i_d_rs2_used(rs2u),
    .i_e_w_idx(widx), .i_e_wb_en(wb), .i_e_is_load(ld), .i_e_br_taken(br), .i_e_mc_req(mc),
    .i_mc_done(done), .o_mc_start(mc_start), .o_stall_f(stall_f), .o_stall_d(stall_d),
    .o_stall_e(stall_e), .o_flush_d(flush_d), .o_flush_e(flush_e), .o_pc_sel(pc_sel),
    .o_mc_busy(busy), .o_mc_err(err), .o_stall_cnt(cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) assert (!(mc && br));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    {rs1, rs2, widx} = '0;
    {rs1u, rs2u, wb, ld, br, mc, done} = '0;
  endtask

  task automatic rand_in();
    rs1  = IDX_W'($urandom_range(0, 3));
    rs2  = IDX_W'($urandom_range(0, 3));
    widx = IDX_W'($urandom_range(0, 3));
    rs1u = 1'($urandom);
    rs2u = 1'($urandom);
    wb   = ($urandom_range(0, 3) != 0);
    ld   = 1'($urandom);
    mc   = ($urandom_range(0, 9) == 0);
    br   = !mc && ($urandom_range(0, 5) == 0);
    done = ($urandom_range(0, 5) == 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".start"}, mc_start, 0);
    chk({tag, ".stall_f"}, stall_f, 0);
    chk({tag, ".stall_d"}, stall_d, 0);
    chk({tag, ".stall_e"}, stall_e, 0);
    chk({tag, ".flush_d"}, flush_d, 0);
    chk({tag, ".flush_e"}, flush_e, 0);
    chk({tag, ".pc_sel"}, pc_sel, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  // One clock: check outputs against the rules for the current inputs, then advance the model.
  task automatic cyc(input string tag);
    bit hz, e_st, e_sf, e_se, e_fd, e_fe, e_pc;
    #1;
    hz = ld && wb && widx != 0 && ((rs1u && rs1 == widx) || (rs2u && rs2 == widx));
    {e_st, e_sf, e_se, e_fd, e_fe, e_pc} = '0;
    if (!m_busy) begin
      if (mc) {e_st, e_sf, e_se} = 3'b111;
      else if (br) {e_pc, e_fd, e_fe} = 3'b111;
      else if (hz) {e_sf, e_fe} = 2'b11;
    end else if (!done) {e_sf, e_se} = 2'b11;
    chk({tag, ".start"}, mc_start, e_st);
    chk({tag, ".stall_f"}, stall_f, e_sf);
    chk({tag, ".stall_d"}, stall_d, e_sf);
    chk({tag, ".stall_e"}, stall_e, e_se);
    chk({tag, ".flush_d"}, flush_d, e_fd);
    chk({tag, ".flush_e"}, flush_e, e_fe);
    chk({tag, ".pc_sel"}, pc_sel, e_pc);
    chk({tag, ".busy"}, busy, m_busy);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".cnt"}, cnt, m_cnt);
    if (e_sf && m_cnt < CMAX) m_cnt++;
    if (!m_busy) begin
      if (mc) begin m_busy = 1; m_waited = 0; end
    end else if (done) m_busy = 0;
    else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin m_err = 1; m_busy = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      mc = 1;
      br = 0;
      #3;
      chk_quiet("rst_hold");
      chk("rst_hold.err", err, 0);
      chk("rst_hold.cnt", cnt, 0);
    end
    idle();
    @(negedge clk) rst = 1;
    @(posedge clk) #1;
    ld = 1; wb = 1; widx = 5; rs1 = 5; rs1u = 1;
    cyc("lu");
    chk("lu.cnt1", cnt, 1);
    widx = 0; rs1 = 0;
    cyc("lu_x0");
    widx = 7; rs2 = 7; rs2u = 1; rs1 = 3; br = 1;
    cyc("br_hz");
    idle();
    cyc("idle");
    mc = 1;
    cyc("mc_req");
    mc = 0;
    repeat (2) cyc("mc_wait");
    done = 1;
    cyc("mc_done");
    done = 0;
    cyc("mc_after");
    mc = 1;
    cyc("tmo_req");
    mc = 0;
    repeat (TIMEOUT + 2) cyc("tmo");
    chk("tmo.err", err, 1);
    mc = 1;
    cyc("op2_req");
    mc = 0;
    cyc("op2_wait");
    done = 1;
    cyc("op2_done");
    for (int i = 0; i < 400; i++) begin
      rand_in();
      cyc("rnd");
    end
    idle();
    while (m_busy) cyc("drain");
    mc = 1;
    cyc("rmo_req");
    mc = 0;
    cyc("rmo_wait");
    #2 rst = 0;
    #1;
    chk_quiet("rmo");
    chk("rmo.err", err, 0);
    chk("rmo.cnt", cnt, 0);
    m_busy = 0; m_err = 0; m_cnt = 0;
    @(negedge clk) rst = 1;
    @(posedge clk) #1;
    done = 1;
    cyc("stray_done");
    done = 0;
    cyc("stray_after");
    ld = 1; wb = 1; widx = 2; rs2 = 2; rs2u = 1;
    repeat (20) cyc("sat");
    chk("sat.final", cnt, CMAX);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
